status_writer: RTL
==================

STATUS_WRITER -- requirements
Module: status_writer

Interface
REQ-001 SHALL have parameter NUM_OF_INTERRUPTS, default 1, number of status request channels.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 8, ID width on the AXI4 write master.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 64, AXI4 write address width (max 64).
REQ-004 SHALL have parameter AXI_WR_ID, default 0, constant value driven on m_axi_awid.
REQ-005 SHALL have these ports (name direction width meaning), with one clock and a synchronous active-high reset:
- s_axi_clk  in  1  clock for all logic
- s_axi_rst  in  1  synchronous active-high reset
- status_req  in  NUM_OF_INTERRUPTS  per-channel level request, held until acked
- status_qword  in  64*NUM_OF_INTERRUPTS  per-channel 64-bit status payload
- status_addr  in  64*NUM_OF_INTERRUPTS  per-channel host byte address of payload
- status_ack  out  NUM_OF_INTERRUPTS  one-cycle per-channel completion pulse
- m_axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  AXI_ID_WIDTH/AXI_ADDR_WIDTH/8/3/2/1  AXI4 write address
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wlast/wvalid  out  64/8/1/1  AXI4 write data
- m_axi_wready  in  1
- m_axi_bid/bresp/bvalid  in  AXI_ID_WIDTH/2/1  AXI4 write response
- m_axi_bready  out  1
- busy  out  1  high whenever state is not IDLE
- wr_err_cnt  out  16  saturating count of non-OKAY responses and misaligned addresses

Function
REQ-006 SHALL implement the states IDLE, XFER, RESP and ACK.
REQ-007 In IDLE with any status_req bit high, SHALL grant exactly one channel round-robin, searching from (last granted + 1) mod NUM_OF_INTERRUPTS; after reset, the search starts at channel 0.
REQ-008 At grant, SHALL latch the channel index, status_addr[63:0] and status_qword of that channel, and go to XFER; later input changes SHALL NOT affect the transfer.
REQ-009 On entering XFER, SHALL assert awvalid and wvalid together in the cycle after grant, with: awaddr = latched address[AXI_ADDR_WIDTH-1:3] with 3'b000 appended, awlen=0, awsize=3, awburst=INCR(01), wstrb=8'hFF, wlast=1, wdata = latched qword.
REQ-010 SHALL clear awvalid and wvalid independently, each on its own handshake; if both handshakes occur in the same cycle, both SHALL clear in that cycle.
REQ-011 awaddr, wdata and the other payload signals SHALL stay stable while their valid is high.
REQ-012 SHALL move to RESP when both handshakes have completed, and SHALL hold bready high only in RESP.
REQ-013 On the bvalid&&bready handshake in RESP, SHALL go to ACK; if bresp != 2'b00, SHALL increment wr_err_cnt.
REQ-014 In ACK, SHALL drive status_ack[granted] high for exactly one cycle (a registered output), then return to IDLE.
REQ-015 Channel acknowledgement:
- the ACK cycle SHALL NOT perform a new grant;
- the earliest re-grant is the following IDLE cycle;
- by that cycle the requester has dropped the acked channel's status_req.
REQ-016 If latched address[2:0] != 0, SHALL still perform the write at the aligned address and SHALL increment wr_err_cnt once.
REQ-017 A misaligned address combined with a non-OKAY bresp SHALL increment wr_err_cnt by 2 in total.
REQ-018 wr_err_cnt SHALL saturate at 16'hFFFF and SHALL never wrap.
REQ-019 At most one write SHALL be outstanding; m_axi_bid is ignored.
REQ-020 With awready, wready and bvalid always high, the minimum latency SHALL be:
- cycle 0: status_req rises and grant occurs;
- cycle 1: awvalid/wvalid handshake;
- cycle 2: B handshake;
- cycle 3: status_ack pulse.
A new grant SHALL occur no earlier than cycle 4.
REQ-021 Simultaneous requests SHALL all be served in round-robin order, and no channel SHALL be served twice while another channel waits.

Reset
REQ-022 While s_axi_rst is high at a clock edge, SHALL set:
- state to IDLE and the round-robin pointer so the next search starts at channel 0;
- awvalid, wvalid, bready, status_ack and busy to 0;
- wr_err_cnt to 0;
- latched address and qword to 0.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer without issuing status_ack; the AXI slave is reset in the same domain.

Verification
REQ-024 The bench SHALL cover a single write: ch0 request, addr=0x0000_0001_0000_0040, qword=0x05, all readies high -> one AW at 0x1_0000_0040 with awlen=0, one W with wdata=0x05 and wstrb=0xFF, status_ack[0] high in cycle 3 only.
REQ-025 The bench SHALL cover back-pressure: wready low for 5 cycles while awready is high -> awvalid drops after 1 cycle, wvalid is held 6 cycles with wdata stable, bready rises only after both handshakes.
REQ-026 The bench SHALL cover arbitration: NUM_OF_INTERRUPTS=4, channels 0/2/3 request simultaneously and re-request after each ack -> grant order 0,2,3,0,2,3, never the same channel twice consecutively while another waits.
REQ-027 The bench SHALL cover errors: bresp=SLVERR on one write and addr=0x...43 on another -> wr_err_cnt=2, both channels acked, the misaligned write goes to 0x...40.
REQ-028 The bench SHALL cover reset: s_axi_rst high during RESP -> next cycle state IDLE, bready=0, no status_ack, wr_err_cnt=0; a request after reset is served from channel 0.

Source files
------------

// File: rtl/status_writer_if.sv
// rtl/status_writer_if.sv - AXI4 write-channel bundle (AW/W/B) used by the status writer
interface status_writer_if #(
   parameter int AXI_ID_WIDTH   = 8,
   parameter int AXI_ADDR_WIDTH = 64
);
   logic [AXI_ID_WIDTH-1:0]   awid;
   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic [7:0]                awlen;
   logic [2:0]                awsize;
   logic [1:0]                awburst;
   logic                      awvalid;
   logic                      awready;
   logic [63:0]               wdata;
   logic [7:0]                wstrb;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;
   logic [AXI_ID_WIDTH-1:0]   bid;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/status_writer.sv
// rtl/status_writer.sv - round-robin arbiter that posts one 64-bit status word per request
// over a single-beat AXI4 write, then pulses the requesting channel's ack
module status_writer #(
   parameter int NUM_OF_INTERRUPTS = 1,
   parameter int AXI_ID_WIDTH      = 8,
   parameter int AXI_ADDR_WIDTH    = 64,
   parameter int AXI_WR_ID         = 0
) (
   input  logic                           s_axi_clk,
   input  logic                           s_axi_rst,
   input  logic [NUM_OF_INTERRUPTS-1:0]   status_req,
   input  logic [64*NUM_OF_INTERRUPTS-1:0] status_qword,
   input  logic [64*NUM_OF_INTERRUPTS-1:0] status_addr,
   output logic [NUM_OF_INTERRUPTS-1:0]   status_ack,
   status_writer_if.master                m_axi,
   output logic                           busy,
   output logic [15:0]                    wr_err_cnt
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_ACK  = 2'd3;
   localparam int IW = (NUM_OF_INTERRUPTS > 1) ? $clog2(NUM_OF_INTERRUPTS) : 1;

   logic [1:0]                   state;
   logic [IW-1:0]                rr_start;
   logic [NUM_OF_INTERRUPTS-1:0] grant_oh;
   logic [63:0]                  lat_addr;
   logic [63:0]                  lat_qword;
   logic                         aw_valid_q;
   logic                         w_valid_q;

   logic                         sel_found;
   logic [NUM_OF_INTERRUPTS-1:0] sel_oh;
   logic [IW-1:0]                sel_next;
   logic [63:0]                  sel_addr;
   logic [63:0]                  sel_qword;
   logic                         aw_done;
   logic                         w_done;
   logic [1:0]                   err_inc;
   logic [16:0]                  err_sum;

   // Two passes: channels at/after the pointer first, then the wrapped-around ones.
   always_comb begin
      sel_found = 1'b0;
      sel_oh    = '0;
      sel_next  = '0;
      sel_addr  = '0;
      sel_qword = '0;
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < NUM_OF_INTERRUPTS; j++) begin
            if (!sel_found && status_req[j] && ((p == 0) == (j >= int'(rr_start)))) begin
               sel_found = 1'b1;
               sel_oh[j] = 1'b1;
               sel_addr  = status_addr[64*j +: 64];
               sel_qword = status_qword[64*j +: 64];
               sel_next  = (j == NUM_OF_INTERRUPTS - 1) ? '0 : IW'(j + 1);
            end
         end
      end
   end

   assign aw_done = !aw_valid_q || m_axi.awready;
   assign w_done  = !w_valid_q  || m_axi.wready;
   assign err_inc = {1'b0, lat_addr[2:0] != 3'b000} + {1'b0, m_axi.bresp != 2'b00};
   assign err_sum = {1'b0, wr_err_cnt} + {15'b0, err_inc};

   always_ff @(posedge s_axi_clk) begin
      if (s_axi_rst) begin
         state      <= ST_IDLE;
         rr_start   <= '0;
         grant_oh   <= '0;
         lat_addr   <= '0;
         lat_qword  <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         status_ack <= '0;
         wr_err_cnt <= '0;
      end else begin
         status_ack <= '0;
         case (state)
            ST_IDLE: begin
               if (sel_found) begin
                  state      <= ST_XFER;
                  grant_oh   <= sel_oh;
                  rr_start   <= sel_next;
                  lat_addr   <= sel_addr;
                  lat_qword  <= sel_qword;
                  aw_valid_q <= 1'b1;
                  w_valid_q  <= 1'b1;
               end
            end
            ST_XFER: begin
               if (aw_valid_q && m_axi.awready) aw_valid_q <= 1'b0;
               if (w_valid_q && m_axi.wready)   w_valid_q  <= 1'b0;
               if (aw_done && w_done)           state      <= ST_RESP;
            end
            ST_RESP: begin
               if (m_axi.bvalid) begin
                  state      <= ST_ACK;
                  status_ack <= grant_oh;
                  // A misaligned address and an error response each count once.
                  wr_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
               end
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign m_axi.awid    = AXI_ID_WIDTH'(AXI_WR_ID);
   assign m_axi.awaddr  = {lat_addr[AXI_ADDR_WIDTH-1:3], 3'b000};
   assign m_axi.awlen   = 8'd0;
   assign m_axi.awsize  = 3'd3;
   assign m_axi.awburst = 2'b01;
   assign m_axi.awvalid = aw_valid_q;
   assign m_axi.wdata   = lat_qword;
   assign m_axi.wstrb   = 8'hFF;
   assign m_axi.wlast   = 1'b1;
   assign m_axi.wvalid  = w_valid_q;
   assign m_axi.bready  = (state == ST_RESP);
   assign busy          = (state != ST_IDLE);

   // Only one write is ever outstanding, so the response ID carries no information.
   logic unused_bid;
   assign unused_bid = ^m_axi.bid;
endmodule
